// File: rtl/id_pipe.sv
// Decode stage for a MIPS-style pipeline: register file, immediate extension, load-use stall and ID/EX register.
// Define ID_PIPE_BYPASS_EN to let a same-edge write-back reach the captured operands (write-through).
module id_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_N  = 32,
    parameter int AW     = $clog2(REG_N)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Ins_valid,
    input  logic [31:0]       Ins,
    input  logic              Flush,
    input  logic              Wen,
    input  logic [AW-1:0]     Waddr,
    input  logic [DATA_W-1:0] Wdata,
    output logic              Stall,
    output logic              Ex_valid,
    output logic [DATA_W-1:0] Rdata1,
    output logic [DATA_W-1:0] Rdata2,
    output logic [DATA_W-1:0] Ed32,
    output logic [AW-1:0]     Ex_rs,
    output logic [AW-1:0]     Ex_rt,
    output logic [AW-1:0]     Ex_rd,
    output logic [5:0]        Ex_op,
    output logic [5:0]        Ex_funct
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    logic [DATA_W-1:0] regs [REG_N];

    logic [5:0]        op;
    logic [5:0]        funct;
    logic [AW-1:0]     rs;
    logic [AW-1:0]     rt;
    logic [AW-1:0]     rd;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] imm_ext;
    logic              reads_rt;

    assign op    = Ins[31:26];
    assign funct = Ins[5:0];
    assign rs    = Ins[21 +: AW];
    assign rt    = Ins[16 +: AW];
    assign rd    = Ins[11 +: AW];

    // NOTE: every variable driven here gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rs_val   = (rs == '0) ? '0 : regs[rs];
        rt_val   = (rt == '0) ? '0 : regs[rt];
        imm_ext  = {{(DATA_W-16){Ins[15]}}, Ins[15:0]};
        reads_rt = 1'b0;
`ifdef ID_PIPE_BYPASS_EN
        if (Wen && Waddr != '0 && Waddr == rs) rs_val = Wdata;
        if (Wen && Waddr != '0 && Waddr == rt) rt_val = Wdata;
`endif
        if (op == OP_ANDI || op == OP_ORI || op == OP_XORI)
            imm_ext = {{(DATA_W-16){1'b0}}, Ins[15:0]};
        if (op == OP_RTYPE || op == OP_SW || op == OP_BEQ || op == OP_BNE)
            reads_rt = 1'b1;
    end

    // Load-use: the lw in ID/EX has not produced its data yet; Flush squashes the consumer anyway.
    assign Stall = !Flush && Ex_valid && (Ex_op == OP_LW) && (Ex_rt != '0) && Ins_valid &&
                   ((Ex_rt == rs) || (reads_rt && Ex_rt == rt));

    // NOTE: the register file is cleared on reset because software relies on all registers starting at zero.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < REG_N; i++) regs[i] <= '0;
        end else if (Wen && Waddr != '0) begin
            regs[Waddr] <= Wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            Ex_valid <= 1'b0;
            Rdata1   <= '0;
            Rdata2   <= '0;
            Ed32     <= '0;
            Ex_rs    <= '0;
            Ex_rt    <= '0;
            Ex_rd    <= '0;
            Ex_op    <= '0;
            Ex_funct <= '0;
        end else if (Flush || Stall || !Ins_valid) begin
            // Bubble: only the valid bit drops, payload fields hold.
            Ex_valid <= 1'b0;
        end else begin
            Ex_valid <= 1'b1;
            Rdata1   <= rs_val;
            Rdata2   <= rt_val;
            Ed32     <= imm_ext;
            Ex_rs    <= rs;
            Ex_rt    <= rt;
            Ex_rd    <= rd;
            Ex_op    <= op;
            Ex_funct <= funct;
        end
    end

endmodule
